// File: rtl/spi_fnd_pkg.sv
// Shared definitions for the SPI-to-seven-segment receiver.
//   state_t   : receiver FSM states
//   *_IDLE    : reset/idle levels of the SPI pins as seen by the synchronisers
//   cnt_w()   : bit-counter width for a given frame width
package spi_fnd_pkg;

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    // counter must be able to represent DW itself
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_fnd_rx_if.sv
// SPI bus between an external master and the receiver.
//   spi_sclk : serial clock, idles low (mode 0)
//   spi_cs_n : chip select, active low
//   spi_mosi : serial data, MSB first
interface spi_fnd_rx_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;

    modport master (output spi_sclk, output spi_cs_n, output spi_mosi);
    modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_mosi);
endinterface

// File: rtl/sync_ff.sv
// STAGES-deep flop chain bringing one asynchronous bit into the clk domain.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (resets to RST_VAL)
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= {STAGES{RST_VAL}};
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/spi_fnd_rx.sv
// SPI mode-0 slave receiver. Oversamples the SPI pins on clk, shifts in
// frames of BYTES bytes MSB first and holds the last complete frame for
// the downstream seven-segment decoders (digit i = data_out[4i+3:4i]).
//   clk, rst_n : system clock, async active-low reset
//   spi        : SPI bus (slave side)
//   data_out   : last complete frame
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : one-cycle pulse when a frame is aborted by cs_n rising
//   busy       : high while receiving (state RECV)
module spi_fnd_rx
    import spi_fnd_pkg::*;
#(
    parameter int BYTES       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_fnd_rx_if.slave          spi,
    output logic [8*BYTES-1:0]   data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int DW = 8 * BYTES;
    localparam int CW = cnt_w(DW);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_h, cs_h;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi.spi_sclk), .q(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(spi.spi_cs_n), .q(cs_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi.spi_mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_h <= SCLK_IDLE;
            cs_h   <= CS_IDLE;
        end else begin
            sclk_h <= sclk_s;
            cs_h   <= cs_s;
        end
    end

    logic sclk_rise, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_h;
    assign cs_fall   = ~cs_s & cs_h;
    assign cs_rise   = cs_s & ~cs_h;

    // The cs synchroniser resets to "deselected", so releasing reset while
    // the master holds cs_n low would look like a fresh falling edge. We only
    // arm once the flushed chain has shown cs_n high, forcing a full
    // deselect/select cycle before the first frame.
    logic [SYNC_STAGES-1:0] flush_pipe;
    logic                   armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pipe <= '0;
            armed      <= 1'b0;
        end else begin
            flush_pipe <= {flush_pipe[SYNC_STAGES-2:0], 1'b1};
            armed      <= armed | (flush_pipe[SYNC_STAGES-1] & cs_s);
        end
    end

    // Only DW-1 bits need storing: the last bit comes straight from mosi_s.
    state_t          state;
    logic [DW-2:0]   shift;
    logic [CW-1:0]   bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (cs_fall && armed) begin
                        shift   <= '0;
                        bit_cnt <= '0;
                        state   <= RECV;
                        busy    <= 1'b1;
                    end
                end
                RECV: begin
                    // cs_rise wins over a coincident sclk edge
                    if (cs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        shift     <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (sclk_rise) begin
                        shift <= {shift[DW-3:0], mosi_s};
                        if (bit_cnt == CW'(DW - 1)) begin
                            data_out   <= {shift, mosi_s};
                            data_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
